// File: rtl/issue_ex_ctrl.sv
// Issue-side driver of the issue/execute interface: in-order queue, functional-unit select, registered strobes.
// Build option: define ISSUE_BYPASS_EN to let a packet skip the empty queue and issue one edge after it is offered.
`ifndef NUM_FU_ALU
`define NUM_FU_ALU 3
`endif
`ifndef NUM_FU_MULT
`define NUM_FU_MULT 2
`endif
`ifndef NUM_FU_BRANCH
`define NUM_FU_BRANCH 2
`endif
`ifndef MAX_FU_INDEX
`define MAX_FU_INDEX 2
`endif
`ifndef NOP
`define NOP 32'h0000_0013
`endif
`ifndef ZERO_REG
`define ZERO_REG 5'd0
`endif

package issue_ex_pkg;
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;

  localparam logic [2:0] FT_ALU    = 3'd0;
  localparam logic [2:0] FT_MULT   = 3'd1;
  localparam logic [2:0] FT_BRANCH = 3'd2;
  localparam logic [2:0] FT_LOAD   = 3'd3;
  localparam logic [2:0] FT_STORE  = 3'd4;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] npc;
    logic [31:0] rs1_value;
    logic [31:0] rs2_value;
    logic [4:0]  dest_reg;
    logic [3:0]  alu_func;
    logic [2:0]  function_type;
    logic        valid;
  } IS_EX_PACKET;

  function automatic IS_EX_PACKET nop_packet();
    IS_EX_PACKET p;
    p          = '0;
    p.inst     = `NOP;
    p.dest_reg = `ZERO_REG;
    p.alu_func = ALU_ADD;
    return p;
  endfunction
endpackage

module issue_ex_ctrl
  import issue_ex_pkg::*;
#(
  parameter int QUEUE_DEPTH = 4,
  parameter int CNT_W       = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           in_valid,
  input  IS_EX_PACKET                    in_packet,
  output logic                           in_ready,
  input  logic [`NUM_FU_ALU-1:0]         free_alu,
  input  logic [`NUM_FU_MULT-1:0]        free_mult,
  input  logic [`NUM_FU_BRANCH-1:0]      free_branch,
  output IS_EX_PACKET                    is_ex_reg,
  output logic                           alu_en,
  output logic                           mult_en,
  output logic                           branch_en,
  output logic [`MAX_FU_INDEX-1:0]       issue_fu_index,
  output logic                           bad_type,
  output logic [$clog2(QUEUE_DEPTH):0]   count,
  output logic [CNT_W-1:0]               stall_cycles
);
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam int FU_W  = `MAX_FU_INDEX;

  IS_EX_PACKET queue_mem [QUEUE_DEPTH];
  logic [PTR_W-1:0] head_reg, tail_reg;
  logic [CW-1:0]    count_reg;
  logic [CNT_W-1:0] stall_reg;
  logic [`NUM_FU_MULT-1:0] mult_pending_reg;
  IS_EX_PACKET      pkt_reg;
  logic             alu_en_reg, mult_en_reg, branch_en_reg, bad_type_reg;
  logic [FU_W-1:0]  fu_index_reg;

  logic        head_valid;
  IS_EX_PACKET head_pkt, cand_pkt, issue_pkt;
  logic        alu_hit, mult_hit, br_hit;
  logic [FU_W-1:0] alu_idx, mult_idx, br_idx, unit_idx;
  logic        cls_alu, cls_mult, cls_br, cls_ok, unit_hit;
  logic        do_issue, do_pop, do_push, do_bad, do_stall, bypass_take;
  logic [`NUM_FU_MULT-1:0] avail_mult, mult_set;

  assign head_valid = (count_reg != '0);
  assign in_ready   = (count_reg < CW'(QUEUE_DEPTH));
  assign head_pkt   = queue_mem[head_reg];

`ifdef ISSUE_BYPASS_EN
  assign cand_pkt = head_valid ? head_pkt : in_packet;
`else
  assign cand_pkt = head_pkt;
`endif

  // A mult unit stays reserved until stage_ex has visibly dropped its free bit.
  assign avail_mult = free_mult & ~mult_pending_reg;

  always_comb begin
    alu_hit  = 1'b0;
    alu_idx  = '0;
    mult_hit = 1'b0;
    mult_idx = '0;
    br_hit   = 1'b0;
    br_idx   = '0;
    for (int k = `NUM_FU_ALU - 1; k >= 0; k--) begin
      if (free_alu[k]) begin
        alu_hit = 1'b1;
        alu_idx = FU_W'(k);
      end
    end
    for (int k = `NUM_FU_MULT - 1; k >= 0; k--) begin
      if (avail_mult[k]) begin
        mult_hit = 1'b1;
        mult_idx = FU_W'(k);
      end
    end
    for (int k = `NUM_FU_BRANCH - 1; k >= 0; k--) begin
      if (free_branch[k]) begin
        br_hit = 1'b1;
        br_idx = FU_W'(k);
      end
    end
  end

  always_comb begin
    cls_alu  = (cand_pkt.function_type == FT_ALU);
    cls_mult = (cand_pkt.function_type == FT_MULT);
    cls_br   = (cand_pkt.function_type == FT_BRANCH);
    cls_ok   = cls_alu | cls_mult | cls_br;
    unit_hit = (cls_alu & alu_hit) | (cls_mult & mult_hit) | (cls_br & br_hit);
    unit_idx = cls_mult ? mult_idx : (cls_br ? br_idx : alu_idx);
    issue_pkt       = cand_pkt;
    issue_pkt.valid = 1'b1;
  end

  always_comb begin
    do_issue    = 1'b0;
    do_pop      = 1'b0;
    do_bad      = 1'b0;
    do_stall    = 1'b0;
    bypass_take = 1'b0;
    if (head_valid) begin
      if (!cls_ok) begin
        do_pop = 1'b1;
        do_bad = 1'b1;
      end else if (unit_hit) begin
        do_pop   = 1'b1;
        do_issue = 1'b1;
      end else begin
        do_stall = 1'b1;
      end
    end
`ifdef ISSUE_BYPASS_EN
    else if (in_valid && cls_ok && unit_hit) begin
      do_issue    = 1'b1;
      bypass_take = 1'b1;
    end
`endif
    do_push = in_valid && in_ready && !bypass_take;
  end

  for (genvar gi = 0; gi < `NUM_FU_MULT; gi++) begin : g_mult_set
    assign mult_set[gi] = do_issue && cls_mult && (unit_idx == FU_W'(gi));
  end

  always_ff @(posedge clock) begin
    if (do_push && !reset && !flush) begin
      queue_mem[tail_reg] <= in_packet;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head_reg         <= '0;
      tail_reg         <= '0;
      count_reg        <= '0;
      alu_en_reg       <= 1'b0;
      mult_en_reg      <= 1'b0;
      branch_en_reg    <= 1'b0;
      bad_type_reg     <= 1'b0;
      fu_index_reg     <= '0;
      pkt_reg          <= nop_packet();
      mult_pending_reg <= '0;
    end else begin
      if (do_push) tail_reg <= tail_reg + 1'b1;
      if (do_pop)  head_reg <= head_reg + 1'b1;
      count_reg        <= count_reg + CW'(do_push) - CW'(do_pop);
      alu_en_reg       <= do_issue && cls_alu;
      mult_en_reg      <= do_issue && cls_mult;
      branch_en_reg    <= do_issue && cls_br;
      bad_type_reg     <= do_bad;
      fu_index_reg     <= do_issue ? unit_idx : '0;
      pkt_reg          <= do_issue ? issue_pkt : nop_packet();
      mult_pending_reg <= (mult_pending_reg & free_mult) | mult_set;
    end
  end

  // Flush leaves the stall statistic intact; only reset clears it.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_reg <= '0;
    end else if (!flush && do_stall && (stall_reg != '1)) begin
      stall_reg <= stall_reg + 1'b1;
    end
  end

  assign is_ex_reg      = pkt_reg;
  assign alu_en         = alu_en_reg;
  assign mult_en        = mult_en_reg;
  assign branch_en      = branch_en_reg;
  assign issue_fu_index = fu_index_reg;
  assign bad_type       = bad_type_reg;
  assign count          = count_reg;
  assign stall_cycles   = stall_reg;
endmodule

// File: doc/issue_ex_ctrl.md
Name: issue_ex_ctrl

Overview:
- Issue-side driver of the execute-stage interface: owns the producer end of the issue/execute interface.
- Buffers ready instructions in an in-order queue.
- Selects a free functional unit from the `free_alu` / `free_mult` / `free_branch` bitmaps returned by stage_ex.
- Drives registered `is_ex_reg`, `alu_en`, `mult_en`, `branch_en` and `issue_fu_index` into stage_ex.
- Sits between the reservation-station wakeup/select logic and stage_ex.

Parameters:
- QUEUE_DEPTH, 4, number of queue entries; power of two, at least 2.
- CNT_W, 16, width of the stall counter.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- flush  in  1  squash; synchronous, same effect as reset except on `stall_cycles`
- in_valid  in  1  `in_packet` is offered
- in_packet  in  IS_EX_PACKET  instruction to issue; `function_type` selects the unit class
- in_ready  out  1  queue can accept an entry
- free_alu  in  `NUM_FU_ALU  per-unit free bits from stage_ex
- free_mult  in  `NUM_FU_MULT  per-unit free bits from stage_ex
- free_branch  in  `NUM_FU_BRANCH  per-unit free bits from stage_ex
- is_ex_reg  out  IS_EX_PACKET  registered packet to stage_ex
- alu_en  out  1  registered one-cycle issue strobe
- mult_en  out  1  registered one-cycle issue strobe
- branch_en  out  1  registered one-cycle issue strobe
- issue_fu_index  out  `MAX_FU_INDEX  registered index of the selected unit
- bad_type  out  1  registered pulse: head dropped, unsupported `function_type`
- count  out  $clog2(QUEUE_DEPTH)+1  current queue occupancy
- stall_cycles  out  CNT_W  saturating count of cycles the head was valid but blocked

Behaviour:
- Reset / flush values:
  - queue empty, `count`=0, `in_ready`=1
  - all enable strobes 0, `bad_type`=0, `issue_fu_index`=0
  - `is_ex_reg` = NOP packet: `inst`=`NOP, `dest_reg`=`ZERO_REG, `alu_func`=ALU_ADD, `valid`=0, all other fields 0
  - `mult_pending` cleared
  - reset also clears `stall_cycles`; flush does not
  - flush has priority over push, and over issue in the same cycle.
- Queue:
  - circular buffer with head/tail pointers that wrap modulo QUEUE_DEPTH.
  - `in_ready` = (`count` < QUEUE_DEPTH); it does not consider a same-cycle pop.
  - push when `in_valid` && `in_ready`.
  - simultaneous push and pop: `count` unchanged.
- Availability, computed each cycle:
  - ALU unit k available iff `free_alu[k]`.
  - Branch unit k available iff `free_branch[k]`.
  - Mult unit k available iff `free_mult[k]` && !`mult_pending[k]`.
  - `mult_pending[k]` is set on the edge that issues to mult unit k. It clears on the first cycle `free_mult[k]`==0 is sampled, i.e. stage_ex has taken the operation. This prevents double issue while `free_mult` lags by one cycle.
- Selection, head entry only, strictly in order:
  - the class is taken from the head's `function_type`: ALU, MULT or BRANCH.
  - the lowest-index available unit of that class is chosen.
  - if one exists, the head is popped.
  - on the next posedge: the class enable = 1, `issue_fu_index` = chosen unit, `is_ex_reg` = head packet with `valid`=1.
  - otherwise: enables = 0, `is_ex_reg` = NOP packet, `stall_cycles` += 1 (saturates at all-ones).
- Unsupported head `function_type` (LOAD, STORE, anything else): the head is popped, `bad_type` pulses for 1 cycle, nothing is issued.
- At most one enable is high in any cycle; every enable is a one-cycle pulse.
- Latency:
  - an entry pushed at edge t is issued (enable visible) after edge t+1 at the earliest.
  - back-to-back issue of one entry per cycle is possible when units are free.
- Empty queue: enables 0, `is_ex_reg` NOP, no stall count.

Optional Feature:
- Macro: `ISSUE_BYPASS_EN`.
- When defined: if the queue is empty (or is being flushed... no: flush wins) and `in_valid` is offered with an available unit of the correct class, the packet is issued on the next edge without being enqueued. Latency 1 cycle; `count` stays 0.
- When undefined: every packet passes through the queue; minimum latency 2 cycles.

Test Plan:
- Reset, then push one ALU packet (rs1=6, rs2=3, ALU_SUB) with `free_alu`=1 -> `alu_en`=1 for exactly one cycle, 2 edges after push (1 edge with `ISSUE_BYPASS_EN`). `issue_fu_index`=0, `is_ex_reg.rs1_value`=6, `count` returns to 0.
- Push MULT then MULT; hold `free_mult[0]`=1 for one cycle after the first issue, then 0 for 3 cycles, then 1 -> the second `mult_en` appears only after `free_mult[0]` has returned to 1, never in the cycle after the first issue. `stall_cycles` increments by 4.
- Push MULT (unit busy, `free_mult`=0) followed by ALU -> ALU not issued while MULT heads the queue (in order). When `free_mult` goes to 1: `mult_en`, then `alu_en` on the following cycle.
- Fill to QUEUE_DEPTH=4 with `free_alu`=0 -> `in_ready`=0, `count`=4, a 5th `in_valid` is ignored. Pushes across pointer wrap preserve order: `rs1_value` 1,2,3,4 issue in sequence.
- Push a LOAD-type packet -> `bad_type` pulses once, no enable, `count`=0.
- 3 entries queued, assert `flush` together with `in_valid` -> next cycle `count`=0, all enables 0, `is_ex_reg.valid`=0, pushed packet dropped, `stall_cycles` retained.
